// File: rtl/imagine_multichan_outport.sv
// Multi-channel output stage: per-channel FIFOs, round-robin (optionally packet-locked)
// arbitration onto a single registered valid/ready stream, plus EOV completion tracking.
module imagine_multichan_outport #(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ATTRIB_WIDTH = 4,
  parameter int CH_DEPTH     = 4,
  parameter int PACKET_MODE  = 1,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   chData,
  input  logic [NUM_CH*ATTRIB_WIDTH-1:0] chAttrib,
  input  logic [NUM_CH-1:0]              chValid,
  output logic [NUM_CH-1:0]              chReady,
  output logic [DATA_WIDTH-1:0]          dataout,
  output logic [ATTRIB_WIDTH-1:0]        dataAttrib,
  output logic [$clog2(NUM_CH)-1:0]      dataChan,
  output logic                           dataoutValid,
  input  logic                           dataoutReady,
  output logic                           eovInterrupt,
  output logic [CNT_WIDTH-1:0]           eovCount,
  input  logic                           clearEOV
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int PW  = $clog2(CH_DEPTH);
  localparam int WW  = DATA_WIDTH + ATTRIB_WIDTH;
  localparam logic [PW:0]       DEPTH_L = (PW+1)'(CH_DEPTH);
  localparam logic [CHW-1:0]    LAST_CH = CHW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE_CH  = NUM_CH'(1);

  logic [WW-1:0]     fifoMem [NUM_CH][CH_DEPTH];
  logic [PW:0]       wrPtr [NUM_CH];
  logic [PW:0]       rdPtr [NUM_CH];
  logic [PW:0]       wrPtrNext [NUM_CH];
  logic [PW:0]       rdPtrNext [NUM_CH];
  logic [WW-1:0]     headWord [NUM_CH];
  logic [NUM_CH-1:0] wrEn, popEn, notEmpty, eligible;
  logic [CHW-1:0]    lastCh, lockCh, grantCh;
  logic              locked, grantValid, loadEn, eovXfer;

  // FIFO status, head words and next pointer values
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wrEn[i]      = chValid[i] & chReady[i];
      notEmpty[i]  = (wrPtr[i] != rdPtr[i]);
      headWord[i]  = fifoMem[i][rdPtr[i][PW-1:0]];
      wrPtrNext[i] = wrPtr[i] + (PW+1)'(wrEn[i]);
      rdPtrNext[i] = rdPtr[i] + (PW+1)'(popEn[i]);
    end
  end

  // Round-robin grant starting after lastCh; a held packet narrows eligibility to lockCh
  always_comb begin
    if ((PACKET_MODE != 0) && locked) begin
      eligible = notEmpty & (ONE_CH << lockCh);
    end else begin
      eligible = notEmpty;
    end
    grantValid = 1'b0;
    grantCh    = '0;
    // Descending scan so the nearest channel after lastCh wins
    for (int k = NUM_CH; k >= 1; k--) begin
      grantCh    = eligible[CHW'((int'(lastCh) + k) % NUM_CH)] ?
                   CHW'((int'(lastCh) + k) % NUM_CH) : grantCh;
      grantValid = grantValid | eligible[CHW'((int'(lastCh) + k) % NUM_CH)];
    end
    loadEn  = ~dataoutValid | dataoutReady;
    popEn   = (loadEn && grantValid) ? (ONE_CH << grantCh) : '0;
    eovXfer = dataoutValid & dataoutReady & dataAttrib[0];
  end

  // FIFO storage; contents are don't-care until the pointers mark them valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (wrEn[i]) begin
        fifoMem[i][wrPtr[i][PW-1:0]] <= {chAttrib[i*ATTRIB_WIDTH +: ATTRIB_WIDTH],
                                         chData[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // Pointers and registered not-full flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wrPtr[i] <= '0;
        rdPtr[i] <= '0;
      end
      chReady <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wrPtr[i]   <= wrPtrNext[i];
        rdPtr[i]   <= rdPtrNext[i];
        chReady[i] <= ((wrPtrNext[i] - rdPtrNext[i]) != DEPTH_L);
      end
    end
  end

  // Output register, arbitration history and packet lock
  always_ff @(posedge clk) begin
    if (reset) begin
      dataoutValid <= 1'b0;
      dataout      <= '0;
      dataAttrib   <= '0;
      dataChan     <= '0;
      lastCh       <= LAST_CH;
      locked       <= 1'b0;
      lockCh       <= '0;
    end else if (loadEn) begin
      if (grantValid) begin
        dataoutValid            <= 1'b1;
        {dataAttrib, dataout}   <= headWord[grantCh];
        dataChan                <= grantCh;
        lastCh                  <= grantCh;
        lockCh                  <= grantCh;
        if (PACKET_MODE != 0) begin
          locked <= ~headWord[grantCh][DATA_WIDTH];
        end else begin
          locked <= 1'b0;
        end
      end else begin
        dataoutValid <= 1'b0;
      end
    end else begin
      dataoutValid <= dataoutValid;
    end
  end

  // EOV interrupt and saturating counter; a same-cycle EOV transfer beats clearEOV
  always_ff @(posedge clk) begin
    if (reset) begin
      eovInterrupt <= 1'b0;
      eovCount     <= '0;
    end else if (eovXfer) begin
      eovInterrupt <= 1'b1;
      if (clearEOV) begin
        eovCount <= CNT_WIDTH'(1);
      end else if (eovCount != {CNT_WIDTH{1'b1}}) begin
        eovCount <= eovCount + CNT_WIDTH'(1);
      end else begin
        eovCount <= eovCount;
      end
    end else if (clearEOV) begin
      eovInterrupt <= 1'b0;
      eovCount     <= '0;
    end else begin
      eovCount <= eovCount;
    end
  end

endmodule

// File: tb/tb_imagine_multichan_outport.sv
// Self-checking bench: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_imagine_multichan_outport;

  localparam int NCH = 4;
  localparam int DEPTH = 4;
  localparam int MAXCNT = 255;

  typedef logic [19:0] word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] chData;
  logic [15:0] chAttrib;
  logic [3:0]  chValid;
  logic [3:0]  chReady;
  logic [15:0] dataout;
  logic [3:0]  dataAttrib;
  logic [1:0]  dataChan;
  logic        dataoutValid;
  logic        dataoutReady;
  logic        eovInterrupt;
  logic [7:0]  eovCount;
  logic        clearEOV;

  imagine_multichan_outport #(
    .NUM_CH(4), .DATA_WIDTH(16), .ATTRIB_WIDTH(4), .CH_DEPTH(4),
    .PACKET_MODE(1), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .chData(chData), .chAttrib(chAttrib),
    .chValid(chValid), .chReady(chReady), .dataout(dataout),
    .dataAttrib(dataAttrib), .dataChan(dataChan), .dataoutValid(dataoutValid),
    .dataoutReady(dataoutReady), .eovInterrupt(eovInterrupt),
    .eovCount(eovCount), .clearEOV(clearEOV)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit armed = 0;

  // reference model state
  word_t q [NCH][$];
  bit    mValid;
  word_t mWord;
  int    mChan, mLast, mLockCh, mCnt;
  bit    mLocked, mInt;
  logic [3:0] mReady;
  word_t logW [$];
  int    logCh [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic modelEdge();
    word_t inW [NCH];
    bit    wr [NCH];
    int    pick, c;
    if (reset) begin
      for (int i = 0; i < NCH; i++) q[i].delete();
      mValid = 0; mWord = '0; mChan = 0; mLast = NCH - 1;
      mLocked = 0; mLockCh = 0; mInt = 0; mCnt = 0; mReady = 4'b0000;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wr[i]  = chValid[i] && mReady[i];
        inW[i] = {chAttrib[i*4 +: 4], chData[i*16 +: 16]};
      end
      if (mValid && dataoutReady) begin
        logW.push_back(mWord);
        logCh.push_back(mChan);
      end
      if (mValid && dataoutReady && mWord[16]) begin
        mInt = 1;
        mCnt = clearEOV ? 1 : ((mCnt == MAXCNT) ? MAXCNT : mCnt + 1);
      end else if (clearEOV) begin
        mInt = 0;
        mCnt = 0;
      end
      if (!mValid || dataoutReady) begin
        pick = -1;
        for (int k = 1; k <= NCH; k++) begin
          c = (mLast + k) % NCH;
          if (pick < 0 && q[c].size() > 0 && (!mLocked || c == mLockCh)) pick = c;
        end
        if (pick >= 0) begin
          mWord = q[pick].pop_front();
          mValid = 1; mChan = pick; mLast = pick;
          mLocked = !mWord[16]; mLockCh = pick;
        end else begin
          mValid = 0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr[i]) q[i].push_back(inW[i]);
        mReady[i] = (q[i].size() < DEPTH);
      end
    end
  endtask

  task automatic compareAll();
    check("valid", dataoutValid, mValid);
    if (mValid) begin
      check("data", dataout, mWord[15:0]);
      check("attrib", dataAttrib, mWord[19:16]);
      check("chan", dataChan, mChan);
    end
    check("chReady", chReady, mReady);
    check("eovInt", eovInterrupt, mInt);
    check("eovCount", eovCount, mCnt);
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    if (reset) armed = 1;
    @(negedge clk);
    if (armed) compareAll();
  endtask

  task automatic setCh(input int ch, input bit v, input logic [15:0] d, input logic [3:0] a);
    chValid[ch] = v;
    chData[ch*16 +: 16] = d;
    chAttrib[ch*4 +: 4] = a;
  endtask

  task automatic idleInputs();
    chValid = 4'b0000;
    chData = '0;
    chAttrib = '0;
  endtask

  int base, cyc, k, gapLow;
  bit acc;

  initial begin
    reset = 1'b1; clearEOV = 1'b0; dataoutReady = 1'b0;
    idleInputs();
    @(negedge clk);
    cycle();
    check("rst_ready", chReady, 4'b0000);
    check("rst_valid", dataoutValid, 1'b0);
    reset = 1'b0;
    cycle();
    check("post_rst_ready", chReady, 4'b1111);
    check("rst_data", {dataout, dataAttrib, dataChan}, 32'h0);
    check("rst_eov", {eovInterrupt, eovCount}, 32'h0);

    // reset in the middle of a packet
    dataoutReady = 1'b0;
    for (int n = 0; n < 3; n++) begin
      setCh(1, 1'b1, 16'h1000 + 16'(n), 4'h0);
      cycle();
    end
    idleInputs();
    cycle();
    check("mid_held", dataoutValid, 1'b1);
    reset = 1'b1;
    cycle();
    check("mid_rst_valid", dataoutValid, 1'b0);
    check("mid_rst_cnt", eovCount, 8'h00);
    reset = 1'b0;
    cycle();
    check("mid_ready", chReady, 4'b1111);
    dataoutReady = 1'b1;
    base = logW.size();
    gapLow = 0;
    for (int n = 0; n < 5; n++) begin
      cycle();
      if (!dataoutValid) gapLow++;
    end
    check("no_stale", gapLow, 5);
    check("no_stale_log", logW.size() - base, 0);

    // round robin over preloaded channels
    dataoutReady = 1'b0;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < NCH; c++) setCh(c, 1'b1, 16'h2000 + 16'(c*16 + n), 4'h1);
      cycle();
    end
    idleInputs();
    cycle();
    dataoutReady = 1'b1;
    base = logCh.size();
    cyc = 0;
    while (logCh.size() - base < 8 && cyc < 40) begin
      cycle();
      cyc++;
    end
    check("rr_cycles", cyc, 8);
    for (int j = 0; j < 8; j++) begin
      if (base + j < logCh.size()) check("rr_chan", logCh[base + j], j % 4);
      else check("rr_missing", j, 8);
    end

    // packet lock: ch2 A,B,<gap>,C(EOV) must not be interrupted by ch0 D
    clearEOV = 1'b1;
    cycle();
    clearEOV = 1'b0;
    check("pk_clr", eovCount, 8'h00);
    cycle();
    base = logW.size();
    setCh(2, 1'b1, 16'h00A0, 4'h0);
    cycle();
    setCh(2, 1'b1, 16'h00B0, 4'h0);
    setCh(0, 1'b1, 16'h00D0, 4'h1);
    cycle();
    idleInputs();
    cycle();
    cycle();
    check("pk_gap1", dataoutValid, 1'b0);
    setCh(2, 1'b1, 16'h00C0, 4'h1);
    cycle();
    check("pk_gap2", dataoutValid, 1'b0);
    idleInputs();
    cyc = 0;
    while (logW.size() - base < 4 && cyc < 30) begin
      cycle();
      cyc++;
      if (logW.size() - base == 3) check("pk_eov_after_c", eovCount, 8'h01);
    end
    check("pk_count", logW.size() - base, 4);
    if (logW.size() - base >= 4) begin
      check("pk_w0", logW[base][15:0], 16'h00A0);
      check("pk_w1", logW[base + 1][15:0], 16'h00B0);
      check("pk_w2", logW[base + 2][15:0], 16'h00C0);
      check("pk_w3", logW[base + 3][15:0], 16'h00D0);
    end

    // backpressure until ch0 FIFO fills, then drain in order
    dataoutReady = 1'b0;
    base = logW.size();
    k = 0;
    for (int n = 0; n < 10; n++) begin
      setCh(0, k < 6, 16'h4000 + 16'(k), (k == 5) ? 4'h1 : 4'h0);
      acc = chValid[0] && chReady[0];
      cycle();
      if (acc) k++;
    end
    check("bp_accepted", k, 5);
    check("bp_full", chReady[0], 1'b0);
    check("bp_hold", {15'h0, dataoutValid, dataout}, 32'h0001_4000);
    dataoutReady = 1'b1;
    cyc = 0;
    while ((k < 6 || logW.size() - base < 6) && cyc < 40) begin
      setCh(0, k < 6, 16'h4000 + 16'(k), (k == 5) ? 4'h1 : 4'h0);
      acc = chValid[0] && chReady[0];
      cycle();
      if (acc) k++;
      cyc++;
    end
    idleInputs();
    check("bp_count", logW.size() - base, 6);
    for (int j = 0; j < 6; j++) begin
      if (base + j < logW.size()) check("bp_order", logW[base + j][15:0], 16'h4000 + 16'(j));
    end

    // clear/set collision
    clearEOV = 1'b1;
    cycle();
    clearEOV = 1'b0;
    dataoutReady = 1'b0;
    for (int n = 0; n < 4; n++) begin
      setCh(1, 1'b1, 16'h5000 + 16'(n), 4'h1);
      cycle();
    end
    idleInputs();
    cycle();
    dataoutReady = 1'b1;
    for (int n = 0; n < 3; n++) cycle();
    check("col_pre_cnt", eovCount, 8'h03);
    check("col_pre_int", eovInterrupt, 1'b1);
    check("col_pre_valid", dataoutValid, 1'b1);
    clearEOV = 1'b1;
    cycle();
    check("col_int", eovInterrupt, 1'b1);
    check("col_cnt", eovCount, 8'h01);
    dataoutReady = 1'b0;
    cycle();
    check("clr_only", {eovInterrupt, eovCount}, 32'h0);
    clearEOV = 1'b0;

    // saturation
    dataoutReady = 1'b1;
    for (int n = 0; n < 270; n++) begin
      setCh(3, 1'b1, 16'(n), 4'h1);
      cycle();
    end
    idleInputs();
    cycle();
    check("sat_cnt", eovCount, 8'hFF);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++)
        setCh(c, 1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom));
      dataoutReady = ($urandom_range(0, 3) != 0);
      clearEOV = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    idleInputs();
    reset = 1'b0;
    clearEOV = 1'b0;
    dataoutReady = 1'b1;
    for (int n = 0; n < 30; n++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
